// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the MEM-stage load responder and its bus side.
// The state encoding is visible on the debug port, so keep it stable.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2,
        RESP = 2'd3
    } state_e;

    localparam logic [2:0] ARSIZE_WORD = 3'b010;
    localparam logic [1:0] RESP_OKAY   = 2'b00;

    // Word alignment: the low WORD_LSB address bits are forced to zero on the bus.
    localparam int WORD_LSB = 2;

endpackage

// File: rtl/mem_load_responder_if.sv
// MEM-stage load interface and single-beat AXI-style read channel interface.
// Both channels use valid/ready: a beat transfers on a rising clk edge where
// valid and ready are both high; once raised, valid and its payload hold until then.
interface mem_load_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              read_data_req;
    logic [ADDR_W-1:0] read_addr;
    logic              read_data_accept;
    logic              excp_flush;
    logic              ertn_flush;
    logic              read_data_out_req;
    logic [DATA_W-1:0] read_data;
    logic              read_err;

    // MEM stage side
    modport master (
        output read_data_req, read_addr, read_data_accept, excp_flush, ertn_flush,
        input  read_data_out_req, read_data, read_err
    );

    // Responder side
    modport slave (
        input  read_data_req, read_addr, read_data_accept, excp_flush, ertn_flush,
        output read_data_out_req, read_data, read_err
    );
endinterface

interface axi_rd_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arsize;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;

    // Responder side issues the read
    modport master (
        output arvalid, araddr, arsize, rready,
        input  arready, rvalid, rdata, rresp
    );

    // Bus bridge side
    modport slave (
        input  arvalid, araddr, arsize, rready,
        output arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/mem_load_responder.sv
// Turns MEM-stage load requests into single-beat reads, holds the returned word
// until MEM consumes it, and drains/discards beats killed by a pipeline flush.
module mem_load_responder
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic        clk,
    input  logic        resetn,
    mem_load_if.slave   mem,
    axi_rd_if.master    bus,
    output logic [31:0] load_cnt,
    output state_e      dbg_state_o
);

    state_e            state_q, state_d;
    logic              kill_q, kill_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic [31:0]       cnt_q, cnt_d;

    logic flush;
    logic abort;

    assign flush = mem.excp_flush | mem.ertn_flush;
    // While a read is in flight, losing the request is as fatal as a flush.
    assign abort = flush | ~mem.read_data_req;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            kill_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        kill_d  = kill_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                kill_d = 1'b0;
                if (mem.read_data_req && !flush) begin
                    addr_d  = {mem.read_addr[ADDR_W-1:WORD_LSB], {WORD_LSB{1'b0}}};
                    state_d = AR;
                end
            end

            // The address phase always completes; a kill only marks the beat.
            AR: begin
                if (abort) begin
                    kill_d = 1'b1;
                end
                if (bus.arready) begin
                    state_d = R;
                end
            end

            R: begin
                if (abort) begin
                    kill_d = 1'b1;
                end
                if (bus.rvalid) begin
                    if (kill_q || abort) begin
                        state_d = IDLE;
                        kill_d  = 1'b0;
                    end else begin
                        state_d = RESP;
                        data_d  = bus.rdata;
                        err_d   = (bus.rresp != RESP_OKAY);
                    end
                end
            end

            // Flush takes priority over accept so a flushed load is never counted.
            RESP: begin
                if (flush) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end else if (mem.read_data_accept) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                    cnt_d   = cnt_q + 32'd1;
                end
            end

            default: begin
                state_d = IDLE;
                kill_d  = 1'b0;
            end
        endcase
    end

    assign bus.arvalid = (state_q == AR);
    assign bus.araddr  = addr_q;
    assign bus.arsize  = ARSIZE_WORD;
    assign bus.rready  = (state_q == R);

    assign mem.read_data_out_req = (state_q == RESP);
    assign mem.read_data         = data_q;
    assign mem.read_err          = err_q;

    assign load_cnt    = cnt_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_load_responder.sv
// Directed bench for mem_load_responder: a table of load transactions plus
// hand-written sequences for simultaneous flush/handshake and reset corners.
module tb_mem_load_responder;
    import mem_bus_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic              read_data_req    = 1'b0;
    logic [ADDR_W-1:0] read_addr        = '0;
    logic              read_data_accept = 1'b0;
    logic              excp_flush       = 1'b0;
    logic              ertn_flush       = 1'b0;
    logic              arready          = 1'b0;
    logic              rvalid           = 1'b0;
    logic [DATA_W-1:0] rdata            = '0;
    logic [1:0]        rresp            = '0;

    logic              read_data_out_req;
    logic [DATA_W-1:0] read_data;
    logic              read_err;
    logic              arvalid;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arsize;
    logic              rready;
    logic [31:0]       load_cnt;
    state_e            dbg_state;

    mem_load_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mif ();
    axi_rd_if   #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

    assign mif.read_data_req    = read_data_req;
    assign mif.read_addr        = read_addr;
    assign mif.read_data_accept = read_data_accept;
    assign mif.excp_flush       = excp_flush;
    assign mif.ertn_flush       = ertn_flush;
    assign bif.arready          = arready;
    assign bif.rvalid           = rvalid;
    assign bif.rdata            = rdata;
    assign bif.rresp            = rresp;

    assign read_data_out_req = mif.read_data_out_req;
    assign read_data         = mif.read_data;
    assign read_err          = mif.read_err;
    assign arvalid           = bif.arvalid;
    assign araddr            = bif.araddr;
    assign arsize            = bif.arsize;
    assign rready            = bif.rready;

    mem_load_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .mem         (mif.slave),
        .bus         (bif.master),
        .load_cnt    (load_cnt),
        .dbg_state_o (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef enum int {F_NONE, F_AR, F_R, F_RESP} flush_e;

    typedef struct {
        logic [31:0] addr;
        int          ar_wait;
        int          r_wait;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        int          acc_wait;
        flush_e      fl;
        logic [31:0] exp_araddr;
        logic        exp_deliver;
        logic        exp_err;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs[8];

    task automatic run_load(input vec_t v);
        int n;
        read_addr     = v.addr;
        read_data_req = 1'b1;
        tick();
        n = 0;
        while (!arvalid && n < 20) begin
            tick();
            n++;
        end
        chk("ar_latency", n, 0);
        chk("arsize", arsize, 3'b010);
        for (int i = 0; i < v.ar_wait; i++) begin
            chk("araddr_stall", araddr, v.exp_araddr);
            chk("arvalid_stall", arvalid, 1'b1);
            if (v.fl == F_AR && i == 0) excp_flush = 1'b1;
            tick();
            if (excp_flush) begin
                excp_flush    = 1'b0;
                read_data_req = 1'b0;
            end
        end
        chk("araddr", araddr, v.exp_araddr);
        chk("arvalid", arvalid, 1'b1);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk("arvalid_drop", arvalid, 1'b0);
        chk("rready", rready, 1'b1);
        for (int i = 0; i < v.r_wait; i++) begin
            chk("rready_wait", rready, 1'b1);
            if (v.fl == F_R && i == 0) ertn_flush = 1'b1;
            tick();
            if (ertn_flush) begin
                ertn_flush    = 1'b0;
                read_data_req = 1'b0;
            end
        end
        rvalid = 1'b1;
        rdata  = v.rdata;
        rresp  = v.rresp;
        tick();
        rvalid = 1'b0;
        rdata  = 32'hBAD0_BAD0;
        rresp  = 2'b11;
        chk("out_req", read_data_out_req, v.exp_deliver);
        if (v.exp_deliver) begin
            chk("read_data", read_data, v.rdata);
            chk("read_err", read_err, v.exp_err);
            for (int i = 0; i < v.acc_wait; i++) begin
                tick();
                chk("out_req_hold", read_data_out_req, 1'b1);
                chk("read_data_hold", read_data, v.rdata);
                chk("read_err_hold", read_err, v.exp_err);
            end
            if (v.fl == F_RESP) ertn_flush = 1'b1;
            read_data_accept = 1'b1;
            tick();
            read_data_accept = 1'b0;
            ertn_flush       = 1'b0;
            read_data_req    = 1'b0;
            chk("out_req_after_accept", read_data_out_req, 1'b0);
        end else begin
            read_data_req = 1'b0;
            tick();
            chk("out_req_killed", read_data_out_req, 1'b0);
        end
        chk("state_idle", dbg_state, IDLE);
        chk("load_cnt", load_cnt, v.exp_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h1C00_0102, 0, 0, 32'hDEAD_BEEF, 2'b00, 0, F_NONE, 32'h1C00_0100, 1'b1, 1'b0, 32'd1};
        vecs[1] = '{32'h2000_0007, 4, 3, 32'hA5A5_5A5A, 2'b00, 5, F_NONE, 32'h2000_0004, 1'b1, 1'b0, 32'd2};
        vecs[2] = '{32'h3000_0010, 2, 1, 32'h1234_5678, 2'b00, 0, F_AR,   32'h3000_0010, 1'b0, 1'b0, 32'd2};
        vecs[3] = '{32'h0000_0040, 0, 0, 32'hCAFE_F00D, 2'b00, 0, F_NONE, 32'h0000_0040, 1'b1, 1'b0, 32'd3};
        vecs[4] = '{32'h0000_0052, 1, 0, 32'h0000_0000, 2'b10, 1, F_NONE, 32'h0000_0050, 1'b1, 1'b1, 32'd4};
        vecs[5] = '{32'h0000_0060, 0, 2, 32'h5555_AAAA, 2'b00, 0, F_R,    32'h0000_0060, 1'b0, 1'b0, 32'd4};
        vecs[6] = '{32'h0000_0071, 0, 0, 32'h1111_2222, 2'b00, 1, F_RESP, 32'h0000_0070, 1'b1, 1'b0, 32'd4};
        vecs[7] = '{32'hFFFF_FFFF, 0, 1, 32'h8765_4321, 2'b01, 0, F_NONE, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'd5};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_rready", rready, 1'b0);
        chk("rst_out_req", read_data_out_req, 1'b0);
        chk("rst_read_err", read_err, 1'b0);
        chk("rst_read_data", read_data, 32'h0);
        chk("rst_araddr", araddr, 32'h0);
        chk("rst_load_cnt", load_cnt, 32'h0);
        chk("rst_state", dbg_state, IDLE);
        resetn = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) run_load(vecs[i]);

        // Flush alongside a request in IDLE: request ignored
        read_addr     = 32'h0000_00A0;
        read_data_req = 1'b1;
        excp_flush    = 1'b1;
        tick();
        chk("idle_flush_arvalid", arvalid, 1'b0);
        chk("idle_flush_state", dbg_state, IDLE);
        excp_flush    = 1'b0;
        read_data_req = 1'b0;
        tick();
        chk("idle_flush_arvalid2", arvalid, 1'b0);

        // Flush and arready together: beat completes into R, then is discarded
        read_addr     = 32'h0000_00B0;
        read_data_req = 1'b1;
        tick();
        excp_flush = 1'b1;
        arready    = 1'b1;
        tick();
        excp_flush    = 1'b0;
        arready       = 1'b0;
        read_data_req = 1'b0;
        chk("ar_flush_rready", rready, 1'b1);
        chk("ar_flush_arvalid", arvalid, 1'b0);
        rvalid = 1'b1;
        rdata  = 32'h7777_7777;
        tick();
        rvalid = 1'b0;
        chk("ar_flush_out_req", read_data_out_req, 1'b0);
        chk("ar_flush_state", dbg_state, IDLE);

        // Flush and rvalid together: discarded
        read_addr     = 32'h0000_00C0;
        read_data_req = 1'b1;
        tick();
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk("r_flush_rready", rready, 1'b1);
        ertn_flush = 1'b1;
        rvalid     = 1'b1;
        rdata      = 32'h6666_6666;
        tick();
        ertn_flush    = 1'b0;
        rvalid        = 1'b0;
        read_data_req = 1'b0;
        chk("r_flush_out_req", read_data_out_req, 1'b0);
        chk("r_flush_state", dbg_state, IDLE);

        // Request dropped in AR without flush: AR still completes, beat dropped
        read_addr     = 32'h0000_00C4;
        read_data_req = 1'b1;
        tick();
        read_data_req = 1'b0;
        tick();
        chk("drop_arvalid_held", arvalid, 1'b1);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid  = 1'b1;
        tick();
        rvalid = 1'b0;
        chk("drop_out_req", read_data_out_req, 1'b0);
        chk("drop_state", dbg_state, IDLE);

        // rvalid outside R is ignored
        rvalid = 1'b1;
        rdata  = 32'h4444_4444;
        chk("stray_rready", rready, 1'b0);
        tick();
        tick();
        rvalid = 1'b0;
        chk("stray_out_req", read_data_out_req, 1'b0);
        chk("stray_state", dbg_state, IDLE);
        chk("stray_load_cnt", load_cnt, 32'd5);

        // Back-to-back: request kept high across accept for a new load at 0x80
        read_addr     = 32'h0000_0094;
        read_data_req = 1'b1;
        tick();
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = 32'h0BAD_0001;
        rresp   = 2'b00;
        tick();
        rvalid = 1'b0;
        chk("b2b_first_out_req", read_data_out_req, 1'b1);
        chk("b2b_first_data", read_data, 32'h0BAD_0001);
        read_data_accept = 1'b1;
        read_addr        = 32'h0000_0080;
        tick();
        read_data_accept = 1'b0;
        chk("b2b_n1_out_req", read_data_out_req, 1'b0);
        chk("b2b_n1_arvalid", arvalid, 1'b0);
        tick();
        chk("b2b_n2_arvalid", arvalid, 1'b1);
        chk("b2b_n2_araddr", araddr, 32'h0000_0080);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = 32'h0BAD_0002;
        tick();
        rvalid = 1'b0;
        chk("b2b_second_data", read_data, 32'h0BAD_0002);
        read_data_accept = 1'b1;
        tick();
        read_data_accept = 1'b0;
        read_data_req    = 1'b0;
        chk("b2b_load_cnt", load_cnt, 32'd7);
        tick();
        chk("b2b_no_reissue", arvalid, 1'b0);

        // Asynchronous reset in the middle of R
        read_addr     = 32'h0000_00D0;
        read_data_req = 1'b1;
        tick();
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk("rst_mid_rready_before", rready, 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_mid_arvalid", arvalid, 1'b0);
        chk("rst_mid_rready", rready, 1'b0);
        chk("rst_mid_out_req", read_data_out_req, 1'b0);
        chk("rst_mid_read_err", read_err, 1'b0);
        chk("rst_mid_read_data", read_data, 32'h0);
        chk("rst_mid_araddr", araddr, 32'h0);
        chk("rst_mid_load_cnt", load_cnt, 32'h0);
        chk("rst_mid_state", dbg_state, IDLE);
        read_data_req = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        chk("post_rst_state", dbg_state, IDLE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
